fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM byte address. The ROM answers combinationally with the 32-bit little-endian word in the same cycle.
- Captures that word into the IF/ID pipeline register with PC, PC+4 and a valid bit.
- Handles stall, flush and branch/jump redirect from later stages. Enters a sticky fault state on a misaligned or out-of-range fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 2048, ROM size in bytes; legal fetch addresses are 0 .. IMEM_BYTES-4.
- NOP_INST, 32'h0000_0013, instruction word (addi x0,x0,0) inserted as a bubble.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_stall  input  1  hold PC and IF/ID register.
- i_flush  input  1  replace the next IF/ID contents with a bubble.
- i_redirect  input  1  taken branch/jump; load PC from i_redirect_pc.
- i_redirect_pc  input  32  redirect target byte address.
- o_imem_addr  output  11  byte address to ROM; equals pc[10:0].
- i_imem_data  input  32  instruction word returned combinationally by ROM.
- o_inst  output  32  IF/ID instruction.
- o_pc  output  32  IF/ID PC of o_inst.
- o_pc4  output  32  IF/ID o_pc+4.
- o_valid  output  1  IF/ID holds a real instruction.
- o_fault  output  1  sticky fetch fault.
- o_fault_pc  output  32  offending address captured on fault entry.
- o_fetch_cnt  output  32  count of instructions latched with o_valid=1.

Behaviour:
Reset:
- When i_rst_n=0 at a clock edge, PC=RESET_PC and state=BOOT.
- Outputs after that edge: o_inst=NOP_INST, o_pc=0, o_pc4=0, o_valid=0, o_fault=0, o_fault_pc=0, o_fetch_cnt=0.
- Reset overrides every other input, including mid-stall and mid-fault.

States:
- BOOT: one cycle. Drives o_imem_addr=RESET_PC[10:0]; IF/ID stays a bubble. Goes to RUN unconditionally. Fault checks and redirects are ignored in BOOT.
- RUN: normal fetch.
- FAULT: absorbing until reset. PC frozen, IF/ID forced to a bubble (o_valid=0, o_inst=NOP_INST), o_fault=1, o_fetch_cnt frozen, all inputs ignored.

Per-edge priority in RUN (highest first):
1. Redirect:
   - If i_redirect_pc[1:0]!=0 or i_redirect_pc>IMEM_BYTES-4: go to FAULT, o_fault_pc=i_redirect_pc, IF/ID=bubble.
   - Otherwise: PC=i_redirect_pc, IF/ID=bubble.
   - Redirect overrides i_stall and i_flush in the same cycle.
2. Flush without redirect: PC=PC+4 (or held if i_stall=1), IF/ID=bubble.
3. Stall: PC and the entire IF/ID register hold; o_fetch_cnt unchanged.
4. Normal:
   - If PC>IMEM_BYTES-4: go to FAULT, o_fault_pc=PC, IF/ID=bubble.
   - Otherwise: IF/ID <= {i_imem_data, PC, PC+4, valid=1}, PC=PC+4, o_fetch_cnt+1.

Timing and arithmetic:
- Latency: the word at PC appears on o_inst exactly one edge after PC is presented on o_imem_addr.
- A redirect costs one bubble cycle.
- PC arithmetic is 32-bit unsigned; PC+4 wraps modulo 2^32, but the range check faults first.
- o_fetch_cnt wraps 32'hFFFF_FFFF -> 0 without flagging.
- o_imem_addr is combinational from the PC register only, never from inputs, so there is no combinational path i_* -> o_imem_addr.

Test Plan:
- Reset then free-run, ROM returning word=addr^32'hA5A5_0000:
  - Cycle 1 after reset release: o_valid=0.
  - Next edges: o_pc=0,4,8 with o_inst=32'hA5A5_0000, 32'hA5A5_0004, 32'hA5A5_0008.
  - o_pc4=o_pc+4; o_fetch_cnt=1,2,3.
- Stall 3 cycles while o_pc=8: o_pc/o_inst/o_fetch_cnt unchanged for 3 cycles, o_imem_addr stays 12; next edge o_pc=12.
- Redirect to 32'h40 with i_stall=1 simultaneously: next edge o_valid=0 with o_inst=32'h0000_0013; following edge o_pc=32'h40, o_valid=1.
- Redirect to 32'h42 (misaligned): o_fault=1, o_fault_pc=32'h42, o_valid=0; o_fault stays 1 for 10 cycles despite further redirect/flush; i_rst_n=0 for one edge clears o_fault and o_pc=0.
- Sequential run to PC=2044 then PC=2048:
  - Word at 2044 latched valid.
  - Next edge: o_fault=1, o_fault_pc=2048, o_fetch_cnt frozen at its last value.
- Reset asserted mid-stall with o_pc=32'h20: next edge o_valid=0, o_pc=0, o_fetch_cnt=0, state BOOT.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage in front of a combinational instruction ROM.
//   Owns the program counter and presents pc[10:0] as the ROM byte address.
//   It registers the returned word into the IF/ID register together with its
//   PC, PC+4 and a valid bit. Later stages can stall the stage, flush it, or
//   redirect it. A misaligned or out-of-range fetch enters a sticky fault
//   state that only reset clears.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        synchronous active-low reset
//   i_stall        hold PC and IF/ID
//   i_flush        load a bubble into IF/ID
//   i_redirect     taken branch/jump, PC <= i_redirect_pc
//   i_redirect_pc  redirect target byte address
//   o_imem_addr    ROM byte address (pc[10:0])
//   i_imem_data    ROM word for o_imem_addr, same cycle
//   o_inst         IF/ID instruction
//   o_pc           IF/ID PC of o_inst
//   o_pc4          IF/ID PC + 4
//   o_valid        IF/ID holds a real instruction
//   o_fault        sticky fetch fault
//   o_fault_pc     address that caused the fault
//   o_fetch_cnt    number of valid instructions latched
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 2048,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [10:0] o_imem_addr,
  input  logic [31:0] i_imem_data,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic        o_valid,
  output logic        o_fault,
  output logic [31:0] o_fault_pc,
  output logic [31:0] o_fetch_cnt
);

  // Highest byte address at which a whole word can still be fetched.
  localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      state_q,     state_d;
  logic [31:0] pc_q,        pc_d;
  logic [31:0] inst_q,      inst_d;
  logic [31:0] if_pc_q,     if_pc_d;
  logic [31:0] if_pc4_q,    if_pc4_d;
  logic        valid_q,     valid_d;
  logic [31:0] fault_pc_q,  fault_pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic [31:0] pc_plus4;

  // A fetch address is illegal if it is not word aligned or if the word
  // would extend past the end of the ROM.
  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > LAST_ADDR);
  endfunction

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    if_pc_d     = if_pc_q;
    if_pc4_d    = if_pc4_q;
    valid_d     = valid_q;
    fault_pc_d  = fault_pc_q;
    fetch_cnt_d = fetch_cnt_q;

    unique case (state_q)
      ST_BOOT: begin
        // The ROM sees RESET_PC this cycle; its word is latched on the next
        // edge in RUN, so IF/ID remains a bubble here.
        state_d = ST_RUN;
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end

      ST_RUN: begin
        if (i_redirect) begin
          // The word currently fetched is on the wrong path, so it is
          // dropped regardless of stall or flush.
          inst_d  = NOP_INST;
          valid_d = 1'b0;
          if (bad_addr(i_redirect_pc)) begin
            state_d    = ST_FAULT;
            fault_pc_d = i_redirect_pc;
          end else begin
            pc_d = i_redirect_pc;
          end
        end else if (i_flush) begin
          inst_d  = NOP_INST;
          valid_d = 1'b0;
          if (!i_stall) begin
            pc_d = pc_plus4;
          end
        end else if (i_stall) begin
          // Everything holds; the defaults already do that.
        end else if (pc_q > LAST_ADDR) begin
          state_d    = ST_FAULT;
          fault_pc_d = pc_q;
          inst_d     = NOP_INST;
          valid_d    = 1'b0;
        end else begin
          inst_d      = i_imem_data;
          if_pc_d     = pc_q;
          if_pc4_d    = pc_plus4;
          valid_d     = 1'b1;
          pc_d        = pc_plus4;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end

      ST_FAULT: begin
        // Absorbing: IF/ID was set to a bubble on entry and nothing moves.
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end

      default: begin
        state_d = ST_FAULT;
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      inst_q      <= NOP_INST;
      if_pc_q     <= 32'd0;
      if_pc4_q    <= 32'd0;
      valid_q     <= 1'b0;
      fault_pc_q  <= 32'd0;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      if_pc_q     <= if_pc_d;
      if_pc4_q    <= if_pc4_d;
      valid_q     <= valid_d;
      fault_pc_q  <= fault_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // The ROM address comes from the PC register only, so no input reaches
  // o_imem_addr combinationally.
  assign o_imem_addr = pc_q[10:0];
  assign o_inst      = inst_q;
  assign o_pc        = if_pc_q;
  assign o_pc4       = if_pc4_q;
  assign o_valid     = valid_q;
  assign o_fault     = (state_q == ST_FAULT);
  assign o_fault_pc  = fault_pc_q;
  assign o_fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] LAST = 32'd2044;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic [10:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] inst, pc, pc4, fault_pc, fetch_cnt;
  logic        valid, fault;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural view of the stage.
  int          m_state;   // 0 boot, 1 run, 2 fault
  logic [31:0] m_pc, m_inst, m_opc, m_opc4, m_fpc, m_cnt;
  logic        m_valid;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // ROM answers for the 11-bit address the DUT presents.
  assign imem_data = rom({21'd0, imem_addr});

  fetch_stage dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .o_imem_addr  (imem_addr),
    .i_imem_data  (imem_data),
    .o_inst       (inst),
    .o_pc         (pc),
    .o_pc4        (pc4),
    .o_valid      (valid),
    .o_fault      (fault),
    .o_fault_pc   (fault_pc),
    .o_fetch_cnt  (fetch_cnt)
  );

  task automatic model_step();
    if (!rst_n) begin
      m_state = 0; m_pc = 32'd0; m_inst = NOP; m_valid = 1'b0;
      m_opc = 32'd0; m_opc4 = 32'd0; m_fpc = 32'd0; m_cnt = 32'd0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (redirect) begin
        m_inst = NOP; m_valid = 1'b0;
        if ((redirect_pc % 4) != 0 || redirect_pc > LAST) begin
          m_state = 2; m_fpc = redirect_pc;
        end else begin
          m_pc = redirect_pc;
        end
      end else if (flush) begin
        m_inst = NOP; m_valid = 1'b0;
        if (!stall) m_pc = m_pc + 4;
      end else if (!stall) begin
        if (m_pc > LAST) begin
          m_state = 2; m_fpc = m_pc; m_inst = NOP; m_valid = 1'b0;
        end else begin
          m_inst = rom(m_pc); m_opc = m_pc; m_opc4 = m_pc + 4;
          m_valid = 1'b1; m_pc = m_pc + 4; m_cnt = m_cnt + 1;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs();
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", valid); end
    n_cmp++; if (inst !== NOP) begin n_bad++; $display("FAIL reset_inst: got %h want %h", inst, NOP); end
    n_cmp++; if (pc !== 32'd0 || pc4 !== 32'd0) begin n_bad++; $display("FAIL reset_pc: got %h/%h want 0/0", pc, pc4); end
    n_cmp++; if (fault !== 1'b0 || fault_pc !== 32'd0) begin n_bad++; $display("FAIL reset_fault: got %0b/%h want 0/0", fault, fault_pc); end
    n_cmp++; if (fetch_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", fetch_cnt); end
    n_cmp++; if (imem_addr !== 11'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_freerun();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL boot_valid: got %0b want 0", valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (pc !== 32'(4*k) || inst !== rom(32'(4*k)) || pc4 !== 32'(4*k+4) ||
          valid !== 1'b1 || fetch_cnt !== 32'(k+1)) begin
        n_bad++;
        $display("FAIL freerun_%0d: got pc=%h inst=%h pc4=%h v=%0b cnt=%0d want pc=%h inst=%h pc4=%h v=1 cnt=%0d",
                 k, pc, inst, pc4, valid, fetch_cnt, 4*k, rom(32'(4*k)), 4*k+4, k+1);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (pc !== 32'd8 || inst !== rom(32'd8) || fetch_cnt !== 32'd3 || imem_addr !== 11'd12) begin
        n_bad++;
        $display("FAIL stall_%0d: got pc=%h inst=%h cnt=%0d addr=%h want pc=8 inst=%h cnt=3 addr=c",
                 k, pc, inst, fetch_cnt, imem_addr, rom(32'd8));
      end
    end
    stall = 1'b0;
    tick();
    n_cmp++; if (pc !== 32'd12 || fetch_cnt !== 32'd4) begin n_bad++; $display("FAIL stall_release: got pc=%h cnt=%0d want pc=c cnt=4", pc, fetch_cnt); end
  endtask

  task automatic test_redirect_stall();
    redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (valid !== 1'b0 || inst !== NOP) begin n_bad++; $display("FAIL redir_bubble: got v=%0b inst=%h want v=0 inst=%h", valid, inst, NOP); end
    n_cmp++; if (imem_addr !== 11'h40) begin n_bad++; $display("FAIL redir_addr: got %h want 40", imem_addr); end
    tick();
    n_cmp++; if (pc !== 32'h40 || valid !== 1'b1 || inst !== rom(32'h40)) begin n_bad++; $display("FAIL redir_target: got pc=%h v=%0b inst=%h want pc=40 v=1 inst=%h", pc, valid, inst, rom(32'h40)); end
  endtask

  task automatic test_misaligned_fault();
    redirect = 1'b1; redirect_pc = 32'h42;
    tick();
    n_cmp++; if (fault !== 1'b1 || fault_pc !== 32'h42 || valid !== 1'b0) begin n_bad++; $display("FAIL misalign_entry: got f=%0b fpc=%h v=%0b want f=1 fpc=42 v=0", fault, fault_pc, valid); end
    for (int k = 0; k < 10; k++) begin
      redirect = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
      stall = 1'($urandom_range(0, 1)); redirect_pc = {$urandom_range(0, 511), 2'b00};
      tick();
      n_cmp++;
      if (fault !== 1'b1 || fault_pc !== 32'h42 || valid !== 1'b0 || inst !== NOP || fetch_cnt !== 32'd5) begin
        n_bad++;
        $display("FAIL fault_sticky_%0d: got f=%0b fpc=%h v=%0b inst=%h cnt=%0d want f=1 fpc=42 v=0 inst=%h cnt=5",
                 k, fault, fault_pc, valid, inst, fetch_cnt, NOP);
      end
    end
    idle_inputs(); rst_n = 1'b0;
    tick();
    n_cmp++; if (fault !== 1'b0 || pc !== 32'd0) begin n_bad++; $display("FAIL fault_clear: got f=%0b pc=%h want f=0 pc=0", fault, pc); end
  endtask

  task automatic test_range_fault();
    rst_n = 1'b0; idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 512; k++) tick();
    n_cmp++;
    if (pc !== LAST || inst !== rom(LAST) || valid !== 1'b1 || fetch_cnt !== 32'd512) begin
      n_bad++;
      $display("FAIL last_word: got pc=%h inst=%h v=%0b cnt=%0d want pc=%h inst=%h v=1 cnt=512",
               pc, inst, valid, fetch_cnt, LAST, rom(LAST));
    end
    tick();
    n_cmp++;
    if (fault !== 1'b1 || fault_pc !== 32'd2048 || fetch_cnt !== 32'd512 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL range_fault: got f=%0b fpc=%h cnt=%0d v=%0b want f=1 fpc=800 cnt=512 v=0",
               fault, fault_pc, fetch_cnt, valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    rst_n = 1'b0; idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 9; k++) tick();
    stall = 1'b1;
    tick(); tick();
    n_cmp++; if (pc !== 32'h20 || valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_stall: got pc=%h v=%0b want pc=20 v=1", pc, valid); end
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (valid !== 1'b0 || pc !== 32'd0 || fetch_cnt !== 32'd0 || inst !== NOP) begin
      n_bad++;
      $display("FAIL reset_mid_stall: got v=%0b pc=%h cnt=%0d inst=%h want v=0 pc=0 cnt=0 inst=%h", valid, pc, fetch_cnt, inst, NOP);
    end
    rst_n = 1'b1; stall = 1'b0;
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_boot: got v=%0b want 0", valid); end
    tick();
    n_cmp++; if (pc !== 32'd0 || valid !== 1'b1 || fetch_cnt !== 32'd1) begin n_bad++; $display("FAIL post_reset_first: got pc=%h v=%0b cnt=%0d want pc=0 v=1 cnt=1", pc, valid, fetch_cnt); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      rst_n    = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      stall    = ($urandom_range(0, 99) < 20);
      flush    = ($urandom_range(0, 99) < 10);
      redirect = ($urandom_range(0, 99) < 8);
      case ($urandom_range(0, 9))
        0:       redirect_pc = {$urandom_range(0, 520), 2'b00} | 32'($urandom_range(1, 3));
        1:       redirect_pc = $urandom;
        2:       redirect_pc = 32'd2040 + 32'($urandom_range(0, 2) * 4);
        default: redirect_pc = {$urandom_range(0, 511), 2'b00};
      endcase
      tick();
      n_cmp++;
      if (valid !== m_valid || inst !== m_inst || fault !== (m_state == 2) ||
          fault_pc !== m_fpc || fetch_cnt !== m_cnt || imem_addr !== m_pc[10:0]) begin
        n_bad++;
        $display("FAIL rand_%0d: got v=%0b inst=%h f=%0b fpc=%h cnt=%0d addr=%h want v=%0b inst=%h f=%0b fpc=%h cnt=%0d addr=%h",
                 k, valid, inst, fault, fault_pc, fetch_cnt, imem_addr,
                 m_valid, m_inst, (m_state == 2), m_fpc, m_cnt, m_pc[10:0]);
      end
      if (m_valid) begin
        n_cmp++;
        if (pc !== m_opc || pc4 !== m_opc4) begin
          n_bad++;
          $display("FAIL rand_pc_%0d: got pc=%h pc4=%h want pc=%h pc4=%h", k, pc, pc4, m_opc, m_opc4);
        end
      end
    end
  endtask

  initial begin
    m_state = 0; m_pc = 0; m_inst = NOP; m_valid = 0;
    m_opc = 0; m_opc4 = 0; m_fpc = 0; m_cnt = 0;
    rst_n = 1'b0; idle_inputs();
    test_reset();
    test_freerun();
    test_stall();
    test_redirect_stall();
    test_misaligned_fault();
    test_range_fault();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
